// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the
// UART transmit-side byte FIFO.
package uart_pkg;

  localparam int FIFO_DEPTH      = 16;
  localparam int FIFO_AW         = 4;
  localparam int TX_BUSY_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with registered occupancy flags;
// a push into a full FIFO is accepted only alongside a pop.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic          clk,
  input  logic          res,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  assign do_pop  = pop & ~empty_q;
  assign do_push = push & (~full_q | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is left unreset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers command bytes and hands them to the UART
// transmitter one per busy period.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = FIFO_DEPTH,
  parameter int AW           = FIFO_AW,
  parameter int BUSY_TIMEOUT = TX_BUSY_TIMEOUT
) (
  input  logic          clk,
  input  logic          res,
  input  logic [7:0]    data_in,
  input  logic          en_data_in,
  input  logic          rdy,
  output logic [7:0]    data_out,
  output logic          en_data_out,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          lost
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          en_q, en_d;
  logic          ovf_q, ovf_d;
  logic          lost_q, lost_d;

  logic [7:0]    head;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  logic          push, pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .pop   (pop),
    .wdata (data_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    data_out_d = data_out_q;
    en_d       = 1'b0;
    ovf_d      = ovf_q;
    lost_d     = lost_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && rdy) begin
          pop        = 1'b1;
          data_out_d = head;
          en_d       = 1'b1;
          tmo_d      = '0;
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!rdy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          lost_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A full FIFO still takes a byte when the head leaves on the same edge.
    push = en_data_in && (!fifo_full || pop);
    if (en_data_in && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      data_out_q <= 8'h00;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      data_out_q <= data_out_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      lost_q     <= lost_d;
    end
  end

  assign data_out    = data_out_q;
  assign en_data_out = en_q;
  assign full        = fifo_full;
  assign empty       = fifo_empty;
  assign count       = fifo_count;
  assign overflow    = ovf_q;
  assign lost        = lost_q;

endmodule
